// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types, default timing constants and helpers for the
// traffic phase controller.
//   state_t     - controller state encoding
//   DEF_*       - default parameter values, shared by the RTL and the bench
//   next_phase  - round-robin successor of a phase index
//   max4        - maximum of four lengths, used to size the tick timer
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALL_RED,
        ST_WALK,
        ST_FLASH
    } state_t;

    localparam int unsigned DEF_NUM_PHASES    = 2;
    localparam int unsigned DEF_GREEN_TICKS   = 8;
    localparam int unsigned DEF_MIN_GREEN     = 3;
    localparam int unsigned DEF_YELLOW_TICKS  = 2;
    localparam int unsigned DEF_ALL_RED_TICKS = 1;
    localparam int unsigned DEF_WALK_TICKS    = 5;
    localparam int unsigned DEF_COUNT_W       = 4;

    function automatic int unsigned next_phase(input int unsigned cur, input int unsigned num);
        return (cur + 1 >= num) ? 0 : cur + 1;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// traffic_phase_controller_if: groups the controller's timebase, request and
// lamp/pedestrian signals.
//   master - controller side: takes tick/ped_req/flash, drives lamps and status
//   slave  - environment side: drives tick/ped_req/flash, observes lamps
interface traffic_phase_controller_if #(
    parameter int unsigned NUM_PHASES = 2,
    parameter int unsigned COUNT_W    = 4
);
    localparam int unsigned PHASE_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic                  tick;
    logic [NUM_PHASES-1:0] ped_req;
    logic                  flash;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] ped_walk;
    logic [COUNT_W-1:0]    ped_count;
    logic [PHASE_W-1:0]    phase_idx;

    modport master (
        input  tick, ped_req, flash,
        output red, yellow, green, ped_walk, ped_count, phase_idx
    );

    modport slave (
        output tick, ped_req, flash,
        input  red, yellow, green, ped_walk, ped_count, phase_idx
    );
endinterface

// File: rtl/tlc_tick_timer.sv
// tlc_tick_timer: loadable down-counter advanced by a tick enable.
//   clk, reset_n - clock, asynchronous active-low reset (value <= RESET_VAL)
//   load/load_val - synchronous load, has priority over counting
//   tick         - count enable; the counter holds at zero
//   value        - current count
//   expire       - tick while value is zero
module tlc_tick_timer #(
    parameter int unsigned      COUNT     = 4,
    parameter logic [COUNT-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [COUNT-1:0] load_val,
    input  logic             tick,
    output logic [COUNT-1:0] value,
    output logic             expire
);
    logic [COUNT-1:0] value_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= RESET_VAL;
        end else if (load) begin
            value_q <= load_val;
        end else if (tick && (value_q != '0)) begin
            value_q <= value_q - COUNT'(1);
        end
    end

    assign value  = value_q;
    assign expire = tick && (value_q == '0);
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: round-robin N-phase signal controller with
// per-phase pedestrian service and a flash (fault/night) mode.
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - master modport: tick, ped_req, flash in; red, yellow, green,
//              ped_walk, ped_count, phase_idx out (all decoded from registers)
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int unsigned NUM_PHASES    = DEF_NUM_PHASES,
    parameter int unsigned GREEN_TICKS   = DEF_GREEN_TICKS,
    parameter int unsigned MIN_GREEN     = DEF_MIN_GREEN,
    parameter int unsigned YELLOW_TICKS  = DEF_YELLOW_TICKS,
    parameter int unsigned ALL_RED_TICKS = DEF_ALL_RED_TICKS,
    parameter int unsigned WALK_TICKS    = DEF_WALK_TICKS,
    parameter int unsigned COUNT_W       = DEF_COUNT_W
) (
    input logic                       clk,
    input logic                       reset_n,
    traffic_phase_controller_if.master bus
);
    localparam int unsigned PHASE_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int unsigned MAX_LEN = max4(GREEN_TICKS, YELLOW_TICKS, ALL_RED_TICKS, WALK_TICKS);
    localparam int unsigned TIMER_W = $clog2(MAX_LEN) + 1;

    localparam logic [TIMER_W-1:0] GREEN_LD   = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LD  = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] ALL_RED_LD = TIMER_W'(ALL_RED_TICKS - 1);
    localparam logic [TIMER_W-1:0] WALK_LD    = TIMER_W'(WALK_TICKS - 1);
    // Timer value at or below which MIN_GREEN ticks (including the current one) have elapsed.
    localparam logic [TIMER_W-1:0] GREEN_CUT  = TIMER_W'(GREEN_TICKS - MIN_GREEN);

    if (NUM_PHASES < 2) begin : g_bad_num_phases
        $fatal(1, "NUM_PHASES must be at least 2");
    end
    if (MIN_GREEN > GREEN_TICKS) begin : g_bad_min_green
        $fatal(1, "MIN_GREEN must not exceed GREEN_TICKS");
    end
    if (WALK_TICKS >= (1 << COUNT_W)) begin : g_bad_walk
        $fatal(1, "WALK_TICKS must fit in ped_count");
    end
    if (GREEN_TICKS < 1 || MIN_GREEN < 1 || YELLOW_TICKS < 1 || ALL_RED_TICKS < 1 ||
        WALK_TICKS < 1) begin : g_bad_len
        $fatal(1, "all lengths must be at least 1");
    end

    state_t                state_q, state_d;
    logic [PHASE_W-1:0]    cur_q, cur_d;
    logic [NUM_PHASES-1:0] ped_pend_q, ped_pend_d;
    logic                  flash_ph_q, flash_ph_d;

    logic                  tmr_load;
    logic [TIMER_W-1:0]    tmr_load_val;
    logic [TIMER_W-1:0]    tmr_value;
    logic                  tmr_expire;
    logic                  walk_clr;
    logic [NUM_PHASES-1:0] cur_oh;
    logic [PHASE_W-1:0]    cur_next;
    logic [TIMER_W:0]      walk_cnt;

    assign cur_oh   = NUM_PHASES'(1) << cur_q;
    assign cur_next = PHASE_W'(next_phase(32'(cur_q), NUM_PHASES));
    assign walk_cnt = {1'b0, tmr_value} + (TIMER_W + 1)'(1);

    tlc_tick_timer #(
        .COUNT     (TIMER_W),
        .RESET_VAL (ALL_RED_LD)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .tick     (bus.tick),
        .value    (tmr_value),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ALL_RED;
            cur_q      <= PHASE_W'(NUM_PHASES - 1);
            ped_pend_q <= '0;
            flash_ph_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            ped_pend_q <= ped_pend_d;
            flash_ph_q <= flash_ph_d;
        end
    end

    // Next-state logic; every transition reloads the timer for the state entered.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        flash_ph_d   = flash_ph_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        walk_clr     = 1'b0;

        if (bus.flash && (state_q != ST_FLASH)) begin
            state_d  = ST_FLASH;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                ST_GREEN: begin
                    if (tmr_expire ||
                        (bus.tick && ped_pend_q[cur_q] && (tmr_value <= GREEN_CUT))) begin
                        state_d      = ST_YELLOW;
                        tmr_load     = 1'b1;
                        tmr_load_val = YELLOW_LD;
                    end
                end
                ST_YELLOW: begin
                    if (tmr_expire) begin
                        state_d      = ST_ALL_RED;
                        tmr_load     = 1'b1;
                        tmr_load_val = ALL_RED_LD;
                    end
                end
                ST_ALL_RED: begin
                    if (tmr_expire) begin
                        tmr_load = 1'b1;
                        if (ped_pend_q[cur_q]) begin
                            state_d      = ST_WALK;
                            tmr_load_val = WALK_LD;
                            walk_clr     = 1'b1;
                        end else begin
                            state_d      = ST_GREEN;
                            cur_d        = cur_next;
                            tmr_load_val = GREEN_LD;
                        end
                    end
                end
                ST_WALK: begin
                    if (tmr_expire) begin
                        state_d      = ST_GREEN;
                        cur_d        = cur_next;
                        tmr_load     = 1'b1;
                        tmr_load_val = GREEN_LD;
                    end
                end
                ST_FLASH: begin
                    if (bus.tick) flash_ph_d = ~flash_ph_q;
                    if (!bus.flash) begin
                        state_d      = ST_ALL_RED;
                        tmr_load     = 1'b1;
                        tmr_load_val = ALL_RED_LD;
                    end
                end
                default: begin
                    state_d      = ST_ALL_RED;
                    tmr_load     = 1'b1;
                    tmr_load_val = ALL_RED_LD;
                end
            endcase
        end

        // A new request in the same cycle as the WALK-entry clear stays pending.
        ped_pend_d = (ped_pend_q & ~(walk_clr ? cur_oh : '0)) | bus.ped_req;
    end

    always_comb begin
        bus.red       = '1;
        bus.yellow    = '0;
        bus.green     = '0;
        bus.ped_walk  = '0;
        bus.ped_count = '0;
        unique case (state_q)
            ST_GREEN: begin
                bus.red   = ~cur_oh;
                bus.green = cur_oh;
            end
            ST_YELLOW: begin
                bus.red    = ~cur_oh;
                bus.yellow = cur_oh;
            end
            ST_WALK: begin
                bus.ped_walk  = cur_oh;
                bus.ped_count = COUNT_W'(walk_cnt);
            end
            ST_FLASH: begin
                bus.red    = '0;
                bus.yellow = {NUM_PHASES{flash_ph_q}};
            end
            default: ;
        endcase
    end

    assign bus.phase_idx = cur_q;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with default parameters.
// Expected lamp sequences are written as hand-computed segment tables.
module tb_traffic_phase_controller;
    import tlc_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    logic [12:0] exp_q[$];
    logic [12:0] got;

    traffic_phase_controller_if #(.NUM_PHASES(2), .COUNT_W(4)) bus ();

    traffic_phase_controller #(
        .NUM_PHASES    (2),
        .GREEN_TICKS   (8),
        .MIN_GREEN     (3),
        .YELLOW_TICKS  (2),
        .ALL_RED_TICKS (1),
        .WALK_TICKS    (5),
        .COUNT_W       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {red, yellow, green, ped_walk, ped_count, phase_idx}
    function automatic logic [12:0] exp_out(state_t st, int ph, int cnt, bit fph);
        logic [1:0] oh, r, y, g, w;
        logic [3:0] c;
        oh = 2'b01 << ph;
        r = 2'b11; y = 2'b00; g = 2'b00; w = 2'b00; c = 4'd0;
        case (st)
            ST_GREEN:  begin r = ~oh; g = oh; end
            ST_YELLOW: begin r = ~oh; y = oh; end
            ST_WALK:   begin w = oh; c = 4'(cnt); end
            ST_FLASH:  begin r = 2'b00; y = {2{fph}}; end
            default: ;
        endcase
        return {r, y, g, w, c, 1'(ph)};
    endfunction

    // Appends len expected cycles; div = clocks per tick.
    task automatic push_seg(input state_t st, input int ph, input int len, input int div);
        for (int i = 0; i < len; i++)
            exp_q.push_back(exp_out(st, ph, 5 - i / div, 1'((i / div) % 2)));
    endtask

    task automatic push_base_seq();
        push_seg(ST_ALL_RED, 1, 1, 1); push_seg(ST_GREEN, 0, 8, 1);
        push_seg(ST_YELLOW, 0, 2, 1);  push_seg(ST_ALL_RED, 0, 1, 1);
        push_seg(ST_GREEN, 1, 8, 1);   push_seg(ST_YELLOW, 1, 2, 1);
        push_seg(ST_ALL_RED, 1, 1, 1); push_seg(ST_GREEN, 0, 1, 1);
    endtask

    task automatic do_reset();
        bus.tick = 1'b1; bus.ped_req = 2'b00; bus.flash = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus.tick = 1'b1; bus.ped_req = 2'b11; bus.flash = 1'b1;
        @(negedge clk);
        got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
        checks++;
        if (got !== exp_out(ST_ALL_RED, 1, 0, 0)) begin
            errors++;
            $display("FAIL reset_first: got %b expected %b", got, exp_out(ST_ALL_RED, 1, 0, 0));
        end
        repeat (2) @(negedge clk);
        got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
        checks++;
        if (got !== exp_out(ST_ALL_RED, 1, 0, 0)) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", got, exp_out(ST_ALL_RED, 1, 0, 0));
        end
    endtask

    task automatic test_no_requests();
        do_reset();
        exp_q.delete();
        push_base_seq();
        for (int c = 0; c < exp_q.size(); c++) begin
            got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
            checks++;
            if (got !== exp_q[c]) begin
                errors++;
                $display("FAIL no_requests cycle %0d: got %b expected %b", c, got, exp_q[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ped_early();
        do_reset();
        exp_q.delete();
        push_seg(ST_ALL_RED, 1, 1, 1); push_seg(ST_GREEN, 0, 3, 1);
        push_seg(ST_YELLOW, 0, 2, 1);  push_seg(ST_ALL_RED, 0, 1, 1);
        push_seg(ST_WALK, 0, 5, 1);    push_seg(ST_GREEN, 1, 8, 1);
        push_seg(ST_YELLOW, 1, 2, 1);  push_seg(ST_ALL_RED, 1, 1, 1);
        push_seg(ST_GREEN, 0, 8, 1);   push_seg(ST_YELLOW, 0, 2, 1);
        push_seg(ST_ALL_RED, 0, 1, 1); push_seg(ST_GREEN, 1, 1, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
            checks++;
            if (got !== exp_q[c]) begin
                errors++;
                $display("FAIL ped_early cycle %0d: got %b expected %b", c, got, exp_q[c]);
            end
            bus.ped_req = (c == 1) ? 2'b01 : 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic test_ped_late();
        do_reset();
        exp_q.delete();
        push_seg(ST_ALL_RED, 1, 1, 1); push_seg(ST_GREEN, 0, 8, 1);
        push_seg(ST_YELLOW, 0, 2, 1);  push_seg(ST_ALL_RED, 0, 1, 1);
        push_seg(ST_GREEN, 1, 3, 1);   push_seg(ST_YELLOW, 1, 2, 1);
        push_seg(ST_ALL_RED, 1, 1, 1); push_seg(ST_WALK, 1, 5, 1);
        push_seg(ST_GREEN, 0, 1, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
            checks++;
            if (got !== exp_q[c]) begin
                errors++;
                $display("FAIL ped_late cycle %0d: got %b expected %b", c, got, exp_q[c]);
            end
            bus.ped_req = (c == 6) ? 2'b10 : 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic test_slow_tick();
        do_reset();
        exp_q.delete();
        push_seg(ST_ALL_RED, 1, 1, 3); push_seg(ST_GREEN, 0, 24, 3);
        push_seg(ST_YELLOW, 0, 6, 3);  push_seg(ST_ALL_RED, 0, 3, 3);
        push_seg(ST_GREEN, 1, 9, 3);   push_seg(ST_YELLOW, 1, 6, 3);
        push_seg(ST_ALL_RED, 1, 3, 3); push_seg(ST_WALK, 1, 15, 3);
        push_seg(ST_GREEN, 0, 1, 3);
        for (int c = 0; c < exp_q.size(); c++) begin
            got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
            checks++;
            if (got !== exp_q[c]) begin
                errors++;
                $display("FAIL slow_tick cycle %0d: got %b expected %b", c, got, exp_q[c]);
            end
            bus.tick    = (c % 3 == 0);
            bus.ped_req = (c == 5) ? 2'b10 : 2'b00;  // non-tick edge
            @(negedge clk);
        end
        bus.tick = 1'b1;
    endtask

    task automatic test_flash();
        do_reset();
        exp_q.delete();
        push_seg(ST_ALL_RED, 1, 1, 1); push_seg(ST_GREEN, 0, 4, 1);
        push_seg(ST_FLASH, 0, 4, 1);   push_seg(ST_ALL_RED, 0, 1, 1);
        push_seg(ST_GREEN, 1, 3, 1);   push_seg(ST_YELLOW, 1, 2, 1);
        push_seg(ST_ALL_RED, 1, 1, 1); push_seg(ST_WALK, 1, 5, 1);
        push_seg(ST_GREEN, 0, 1, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
            checks++;
            if (got !== exp_q[c]) begin
                errors++;
                $display("FAIL flash cycle %0d: got %b expected %b", c, got, exp_q[c]);
            end
            bus.ped_req = (c == 2) ? 2'b10 : 2'b00;
            bus.flash   = (c >= 4 && c <= 7);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        exp_q.delete();
        push_seg(ST_ALL_RED, 1, 1, 1); push_seg(ST_GREEN, 0, 3, 1);
        push_seg(ST_YELLOW, 0, 2, 1);  push_seg(ST_ALL_RED, 0, 1, 1);
        push_seg(ST_WALK, 0, 2, 1);
        for (int c = 0; c < exp_q.size(); c++) begin
            got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
            checks++;
            if (got !== exp_q[c]) begin
                errors++;
                $display("FAIL walk_prep cycle %0d: got %b expected %b", c, got, exp_q[c]);
            end
            bus.ped_req = (c == 1) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
            @(negedge clk);
        end
        // Mid-WALK, well away from the next rising edge.
        reset_n = 1'b0;
        #1;
        got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
        checks++;
        if (got !== exp_out(ST_ALL_RED, 1, 0, 0)) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", got, exp_out(ST_ALL_RED, 1, 0, 0));
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        push_base_seq();
        for (int c = 0; c < exp_q.size(); c++) begin
            got = {bus.red, bus.yellow, bus.green, bus.ped_walk, bus.ped_count, bus.phase_idx};
            checks++;
            if (got !== exp_q[c]) begin
                errors++;
                $display("FAIL replay cycle %0d: got %b expected %b", c, got, exp_q[c]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_no_requests();
        test_ped_early();
        test_ped_late();
        test_slow_tick();
        test_flash();
        test_reset_mid_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
